// File: rtl/mips_regfile_sb.sv
// MIPS register file (2 sync read ports, 1 writeback port) with per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to reads and drop the hazard in the WB cycle.
module mips_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int PEND_MAX = 3
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rd_valid,
  output logic              src_hazard,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              issue_ready,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              sb_flush,
  output logic              wb_err
);
  localparam int NREGS = 1 << ADDR_W;
  localparam int CNT_W = $clog2(PEND_MAX + 1);
  localparam logic [CNT_W-1:0] PEND_LIM = CNT_W'(PEND_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:0][CNT_W-1:0]  pend;
  logic [NREGS-1:0]             inc, hit;
  logic [1:0]                   vld_pipe;
  logic                         wb_nz, issue_acc;
  logic                         byp_rs, byp_rt;
  logic [DATA_W-1:0]            rs_next, rt_next;

  assign wb_nz       = wb_en && (wb_addr != '0);
  assign issue_ready = (issue_dst == '0) || (pend[issue_dst] < PEND_LIM);
  assign issue_acc   = issue_valid && issue_ready && (issue_dst != '0);

  // R0 never counts: its inc/hit bits stay 0 and its storage is never written
  always_comb begin
    inc = '0;
    hit = '0;
    for (int r = 1; r < NREGS; r++) begin
      inc[r] = issue_acc && (issue_dst == ADDR_W'(r));
      hit[r] = wb_nz && (wb_addr == ADDR_W'(r));
    end
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    byp_rs  = wb_en && (wb_addr == rs_addr) && (pend[rs_addr] == CNT_ONE);
    byp_rt  = wb_en && (wb_addr == rt_addr) && (pend[rt_addr] == CNT_ONE);
    rs_next = (wb_nz && (wb_addr == rs_addr)) ? wb_data : regs[rs_addr];
    rt_next = (wb_nz && (wb_addr == rt_addr)) ? wb_data : regs[rt_addr];
  end
`else
  always_comb begin
    byp_rs  = 1'b0;
    byp_rt  = 1'b0;
    rs_next = regs[rs_addr];
    rt_next = regs[rt_addr];
  end
`endif

  always_comb begin
    src_hazard = ((rs_addr != '0) && (pend[rs_addr] != '0) && !byp_rs) ||
                 ((rt_addr != '0) && (pend[rt_addr] != '0) && !byp_rt);
  end

  // Simultaneous issue+wb on one register cancels out; flush beats both
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      pend <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (hit[r]) regs[r] <= wb_data;
        if (sb_flush)                           pend[r] <= '0;
        else if (inc[r] && !hit[r])             pend[r] <= pend[r] + CNT_ONE;
        else if (hit[r] && !inc[r] && pend[r] != '0) pend[r] <= pend[r] - CNT_ONE;
      end
    end
  end

  assign vld_pipe[0] = rd_en;
  assign rd_valid    = vld_pipe[1];

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      rs_data     <= '0;
      rt_data     <= '0;
      wb_err      <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (rd_en) begin
        rs_data <= rs_next;
        rt_data <= rt_next;
      end
      if (!sb_flush && wb_nz && (pend[wb_addr] == '0)) wb_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed self-checking bench for mips_regfile_sb; expectations follow REGFILE_BYPASS_EN if defined.
module tb_mips_regfile_sb;
  logic        clk1, rst_n;
  logic        rd_en, issue_valid, wb_en, sb_flush;
  logic [4:0]  rs_addr, rt_addr, issue_dst, wb_addr;
  logic [31:0] wb_data, rs_data, rt_data;
  logic        rd_valid, src_hazard, issue_ready, wb_err;
  int          checks = 0, errors = 0;

  mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .PEND_MAX(3)) dut (
    .clk1(clk1), .rst_n(rst_n), .rd_en(rd_en), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .rd_valid(rd_valid), .src_hazard(src_hazard),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_ready(issue_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .sb_flush(sb_flush), .wb_err(wb_err)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle();
    rd_en = 0; issue_valid = 0; wb_en = 0; sb_flush = 0;
    issue_dst = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic test_reset();
    idle(); rs_addr = 0; rt_addr = 0; rst_n = 0;
    tick(); tick();
    rst_n = 1; #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b exp 0", rd_valid); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err: got %b exp 0", wb_err); end
    checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL reset_rs_data: got %h exp 0", rs_data); end
    rd_en = 1; rs_addr = 5; rt_addr = 31; #1;
    checks++; if (src_hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b exp 0", src_hazard); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_early: got %b exp 0", rd_valid); end
    tick(); rd_en = 0;
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL reset_valid_lat: got %b exp 1", rd_valid); end
    checks++; if (rs_data !== 32'h0 || rt_data !== 32'h0) begin errors++; $display("FAIL reset_read: got %h/%h exp 0/0", rs_data, rt_data); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_drop: got %b exp 0", rd_valid); end
  endtask

  task automatic test_write_read();
    issue_valid = 1; issue_dst = 1; tick(); idle();
    wb_en = 1; wb_addr = 1; wb_data = 32'h0000000A; tick(); idle();
    rd_en = 1; rs_addr = 1; rt_addr = 0; tick(); idle();
    checks++; if (rs_data !== 32'h0000000A) begin errors++; $display("FAIL wr_rd_r1: got %h exp 0000000a", rs_data); end
    rs_addr = 31; tick();
    checks++; if (rs_data !== 32'h0000000A) begin errors++; $display("FAIL rd_hold: got %h exp 0000000a", rs_data); end
    wb_en = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF; tick(); idle();
    rd_en = 1; rs_addr = 0; rt_addr = 0; tick(); idle();
    checks++; if (rs_data !== 32'h0 || rt_data !== 32'h0) begin errors++; $display("FAIL r0_read: got %h/%h exp 0/0", rs_data, rt_data); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL r0_wb_err: got %b exp 0", wb_err); end
  endtask

  task automatic test_hazard();
    issue_valid = 1; issue_dst = 2; tick(); idle();
    rs_addr = 2; rt_addr = 0; #1;
    checks++; if (src_hazard !== 1'b1) begin errors++; $display("FAIL hz_pending: got %b exp 1", src_hazard); end
    wb_en = 1; wb_addr = 2; wb_data = 32'h14; rd_en = 1; #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (src_hazard !== 1'b0) begin errors++; $display("FAIL hz_wb_cycle: got %b exp 0", src_hazard); end
`else
    checks++; if (src_hazard !== 1'b1) begin errors++; $display("FAIL hz_wb_cycle: got %b exp 1", src_hazard); end
`endif
    tick(); idle();
    checks++; if (src_hazard !== 1'b0) begin errors++; $display("FAIL hz_after_wb: got %b exp 0", src_hazard); end
`ifdef REGFILE_BYPASS_EN
    checks++; if (rs_data !== 32'h14) begin errors++; $display("FAIL hz_bypass_data: got %h exp 00000014", rs_data); end
`else
    checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL hz_old_data: got %h exp 0", rs_data); end
`endif
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL hz_wb_err: got %b exp 0", wb_err); end
  endtask

  task automatic test_pending();
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1; issue_dst = 3; #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL pend_issue%0d_ready: got %b exp 1", i, issue_ready); end
      tick();
    end
    idle(); issue_dst = 3; #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL pend_full_r3: got %b exp 0", issue_ready); end
    issue_dst = 4; #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL pend_r4_ready: got %b exp 1", issue_ready); end
    issue_dst = 0; #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL pend_r0_ready: got %b exp 1", issue_ready); end
    issue_valid = 1; tick(); idle();
    rs_addr = 0; rt_addr = 3; #1;
    checks++; if (src_hazard !== 1'b1) begin errors++; $display("FAIL pend_r3_hz: got %b exp 1", src_hazard); end
    wb_en = 1; wb_addr = 3; wb_data = 32'h33; tick(); idle();
    issue_dst = 3; #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL pend_after_wb: got %b exp 1", issue_ready); end
    issue_valid = 1; wb_en = 1; wb_addr = 3; wb_data = 32'h33; tick(); idle();
    issue_dst = 3; #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL pend_same_cycle: got %b exp 1", issue_ready); end
    issue_valid = 1; tick(); idle();
    issue_dst = 3; #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL pend_refill: got %b exp 0", issue_ready); end
  endtask

  task automatic test_flush();
    issue_valid = 1; issue_dst = 2; tick(); idle();
    rs_addr = 2; rt_addr = 3; #1;
    checks++; if (src_hazard !== 1'b1) begin errors++; $display("FAIL fl_pre_hz: got %b exp 1", src_hazard); end
    sb_flush = 1; issue_valid = 1; issue_dst = 5; wb_en = 1; wb_addr = 4; wb_data = 32'h44;
    tick(); idle();
    checks++; if (src_hazard !== 1'b0) begin errors++; $display("FAIL fl_hz: got %b exp 0", src_hazard); end
    rs_addr = 5; rt_addr = 0; #1;
    checks++; if (src_hazard !== 1'b0) begin errors++; $display("FAIL fl_issue_dropped: got %b exp 0", src_hazard); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL fl_wb_err: got %b exp 0", wb_err); end
    rd_en = 1; rs_addr = 2; rt_addr = 3; tick(); idle();
    checks++; if (rs_data !== 32'h14 || rt_data !== 32'h33) begin errors++; $display("FAIL fl_data: got %h/%h exp 00000014/00000033", rs_data, rt_data); end
    rd_en = 1; rs_addr = 4; tick(); idle();
    checks++; if (rs_data !== 32'h44) begin errors++; $display("FAIL fl_wb_write: got %h exp 00000044", rs_data); end
  endtask

  task automatic test_wb_err();
    wb_en = 1; wb_addr = 7; wb_data = 32'h77; tick(); idle();
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b exp 1", wb_err); end
    rd_en = 1; rs_addr = 7; tick(); idle(); tick();
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b exp 1", wb_err); end
    checks++; if (rs_data !== 32'h77) begin errors++; $display("FAIL err_data: got %h exp 00000077", rs_data); end
  endtask

  task automatic test_async_reset();
    issue_valid = 1; issue_dst = 6; tick(); idle();
    rd_en = 1; rs_addr = 7; rt_addr = 6; tick();
    checks++; if (rd_valid !== 1'b1 || src_hazard !== 1'b1 || rs_data !== 32'h77) begin errors++;
      $display("FAIL ar_pre: got v=%b hz=%b d=%h exp 1/1/00000077", rd_valid, src_hazard, rs_data); end
    #2 rst_n = 0; #1;
    checks++; if (rs_data !== 32'h0 || rt_data !== 32'h0) begin errors++; $display("FAIL ar_data: got %h/%h exp 0/0", rs_data, rt_data); end
    checks++; if (rd_valid !== 1'b0 || wb_err !== 1'b0) begin errors++; $display("FAIL ar_flags: got v=%b err=%b exp 0/0", rd_valid, wb_err); end
    checks++; if (src_hazard !== 1'b0) begin errors++; $display("FAIL ar_hz: got %b exp 0", src_hazard); end
    tick(); rst_n = 1; #1;
    tick(); idle();
    checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL ar_reg_cleared: got %h exp 0", rs_data); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hazard();
    test_pending();
    test_flush();
    test_wb_err();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
